// File: rtl/ara_sig_dumper.sv
// ara_sig_dumper: on end-of-computation, streams the signature memory region out as 32-bit words.
// The runtime cycle count and the exit code are latched when end-of-computation is detected.
module ara_sig_dumper #(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned CntWidth  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [63:0]          exit_i,
    input  logic [AddrWidth-1:0] sig_begin_i,
    input  logic [AddrWidth-1:0] sig_end_i,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    output logic                 word_valid_o,
    input  logic                 word_ready_i,
    output logic [31:0]          word_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [62:0]          exit_code_o,
    output logic [CntWidth-1:0]  cycles_o
);
    localparam int unsigned W  = DataWidth / 32;
    localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} state_e;

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q;
    logic [AddrWidth-1:0] addr_q, end_q, addr_nx;
    logic [KW-1:0]        k_q, k_begin;
    logic [DataWidth-1:0] beat_q;
    logic [62:0]          code_q;
    logic                 empty, last_k;

    // k is the word slot inside a beat; tracking it avoids a modulo per word
    assign k_begin = KW'((sig_begin_i >> 2) % AddrWidth'(W));
    assign last_k  = k_q == KW'(W - 1);
    assign addr_nx = addr_q + AddrWidth'(4);
    assign empty   = sig_begin_i >= sig_end_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (exit_i[0]) state_d = empty ? DONE : REQ;
            REQ:     if (mem_gnt_i) state_d = WAIT;
            WAIT:    if (mem_rvalid_i) state_d = EMIT;
            EMIT:    if (word_ready_i) state_d = (addr_nx == end_q) ? DONE : last_k ? REQ : EMIT;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            addr_q <= '0;
            end_q  <= '0;
            k_q    <= '0;
            beat_q <= '0;
            code_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exit_i[0]) begin
                        code_q <= exit_i[63:1];
                        addr_q <= sig_begin_i;
                        end_q  <= sig_end_i;
                        k_q    <= k_begin;
                    end else if (~&cnt_q) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT: if (mem_rvalid_i) beat_q <= mem_rdata_i;
                EMIT: begin
                    if (word_ready_i) begin
                        addr_q <= addr_nx;
                        k_q    <= last_k ? '0 : k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_o    = state_q == REQ;
    assign mem_addr_o   = mem_req_o ? addr_q - AddrWidth'({k_q, 2'b00}) : '0;
    assign word_valid_o = state_q == EMIT;
    assign word_o       = word_valid_o ? beat_q[32*k_q +: 32] : '0;
    assign done_o       = state_q == DONE;
    assign fail_o       = |code_q;
    assign exit_code_o  = code_q;
    assign cycles_o     = cnt_q;
endmodule

// File: tb/tb_ara_sig_dumper.sv
// tb_ara_sig_dumper: directed dumps against a behavioural memory with a scoreboard of expected words.
module tb_ara_sig_dumper;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [63:0]  exit_i = '0;
    logic [63:0]  sig_begin_i = '0;
    logic [63:0]  sig_end_i = '0;
    logic         mem_req_o;
    logic [63:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [127:0] mem_rdata_i;
    logic         word_valid_o;
    logic         word_ready_i = 1'b0;
    logic [31:0]  word_o;
    logic         done_o;
    logic         fail_o;
    logic [62:0]  exit_code_o;
    logic [63:0]  cycles_o;

    logic         a_gnt = 1'b0, m_gnt = 1'b0, a_rvalid = 1'b0, m_rvalid = 1'b0;
    logic [127:0] a_rdata = '0, m_rdata = '0;
    bit           auto_mem = 1'b1;
    bit           rnd_ready = 1'b0;
    int unsigned  max_dly = 0;
    int           vectors = 0, errors = 0, nreq = 0, nwords = 0;
    logic [31:0]  sbq[$];

    assign mem_gnt_i    = auto_mem ? a_gnt : m_gnt;
    assign mem_rvalid_i = auto_mem ? a_rvalid : m_rvalid;
    assign mem_rdata_i  = auto_mem ? a_rdata : m_rdata;

    ara_sig_dumper dut (
        .clk_i(clk_i), .rst_i(rst_i), .exit_i(exit_i),
        .sig_begin_i(sig_begin_i), .sig_end_i(sig_end_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i), .word_o(word_o),
        .done_o(done_o), .fail_o(fail_o), .exit_code_o(exit_code_o), .cycles_o(cycles_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mw(input logic [63:0] a);
        return a[31:0] ^ 32'hC3A5_96E1 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [127:0] beat(input logic [63:0] a);
        logic [127:0] b;
        for (int j = 0; j < 4; j++) b[32*j +: 32] = mw(a + 64'(4*j));
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // memory: grant after a random delay, answer the cycle after the grant
    logic        pend = 1'b0, inreq = 1'b0;
    logic [63:0] paddr, raddr;
    int unsigned wcnt;
    always @(negedge clk_i) begin
        if (rst_i) begin
            pend = 0; inreq = 0; a_gnt = 0; a_rvalid = 0;
        end else begin
            a_rvalid = pend;
            if (pend) a_rdata = beat(paddr);
            pend = 0;
            if (mem_req_o) begin
                if (!inreq) begin
                    inreq = 1; raddr = mem_addr_o; nreq++;
                    wcnt = $urandom_range(0, max_dly);
                    chk("beat_align", 64'(mem_addr_o[3:0]), 64'd0);
                end else begin
                    chk("addr_stable", mem_addr_o, raddr);
                end
                a_gnt = wcnt == 0;
                if (wcnt == 0) begin pend = 1; paddr = mem_addr_o; inreq = 0; end
                else wcnt--;
            end else begin
                a_gnt = 0; inreq = 0;
            end
        end
    end

    // consumer: random backpressure, scoreboard pop on each transfer
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word;
    always @(negedge clk_i) begin
        logic rdy;
        if (rst_i) prev_stall = 0;
        else if (prev_stall) begin
            chk("valid_held", 64'(word_valid_o), 64'd1);
            chk("word_stable", 64'(word_o), 64'(prev_word));
        end
        rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        word_ready_i = rdy;
        if (word_valid_o && rdy && !rst_i) begin
            if (sbq.size() == 0) chk("word_unexpected", 64'(word_valid_o), 64'd0);
            else chk("word", 64'(word_o), 64'(sbq.pop_front()));
            nwords++;
        end
        prev_stall = word_valid_o && !rdy && !rst_i;
        prev_word = word_o;
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_addr"}, mem_addr_o, 64'd0);
        chk({tag, "_valid"}, 64'(word_valid_o), 64'd0);
        chk({tag, "_word"}, 64'(word_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_fail"}, 64'(fail_o), 64'd0);
        chk({tag, "_code"}, 64'(exit_code_o), 64'd0);
        chk({tag, "_cycles"}, cycles_o, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1; exit_i = '0;
        #1 check_reset_vals("rst");
        repeat (2) @(negedge clk_i);
        rst_i = 0;
    endtask

    task automatic run_dump(input string tag, input logic [63:0] b, input logic [63:0] e,
                            input logic [63:0] x, input int n, input int unsigned dly, input bit rnd);
        int i, words, beats;
        max_dly = dly; rnd_ready = rnd; sbq.delete();
        do_reset();
        sig_begin_i = b; sig_end_i = e; nreq = 0; nwords = 0;
        words = b < e ? int'((e - b) / 4) : 0;
        beats = b < e ? int'(((e - 1) >> 4) - (b >> 4) + 1) : 0;
        for (logic [63:0] a = b; a < e; a += 4) sbq.push_back(mw(a));
        repeat (n) @(negedge clk_i);
        exit_i = x; i = 0;
        while (!done_o && i < 500) begin
            @(negedge clk_i);
            exit_i = '0; i++;
        end
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        chk({tag, "_cycles"}, cycles_o, 64'(n));
        chk({tag, "_fail"}, 64'(fail_o), 64'(x[63:1] != 0));
        chk({tag, "_code"}, 64'(exit_code_o), 64'(x[63:1]));
        chk({tag, "_nwords"}, 64'(nwords), 64'(words));
        chk({tag, "_nreq"}, 64'(nreq), 64'(beats));
        chk({tag, "_leftover"}, 64'(sbq.size()), 64'd0);
        if (!rnd && dly == 0) chk({tag, "_latency"}, 64'(i), 64'(1 + 2 * beats + words));
        exit_i = 64'hFF;
        repeat (3) @(negedge clk_i);
        chk({tag, "_code_held"}, 64'(exit_code_o), 64'(x[63:1]));
        chk({tag, "_done_held"}, 64'(done_o), 64'd1);
        chk({tag, "_idle_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_idle_valid"}, 64'(word_valid_o), 64'd0);
        exit_i = '0;
    endtask

    initial begin
        run_dump("base",  64'h8000_0000, 64'h8000_0020, 64'h1, 100, 0, 0);
        run_dump("unal",  64'h8000_0008, 64'h8000_0014, 64'h1, 7, 0, 0);
        run_dump("fail",  64'h8000_0100, 64'h8000_0130, 64'h7, 20, 0, 0);
        run_dump("stall", 64'h8000_0204, 64'h8000_0238, 64'h1, 3, 5, 1);
        run_dump("empty", 64'h8000_0040, 64'h8000_0040, 64'h1, 10, 0, 0);
        run_dump("end0",  64'h8000_0010, 64'h0, 64'h1, 4, 0, 0);
        run_dump("rand",  64'h8000_0300, 64'h8000_0344, 64'h9, 2, 3, 1);

        auto_mem = 0; m_gnt = 0; m_rvalid = 0; rnd_ready = 0; sbq.delete();
        do_reset();
        sig_begin_i = 64'h8000_0000; sig_end_i = 64'h8000_0010; nwords = 0;
        repeat (5) @(negedge clk_i);
        exit_i = 64'h5;
        @(negedge clk_i);
        exit_i = '0;
        chk("abort_req", 64'(mem_req_o), 64'd1);
        chk("abort_addr", mem_addr_o, 64'h8000_0000);
        chk("abort_code", 64'(exit_code_o), 64'd2);
        m_gnt = 1;
        @(negedge clk_i);
        m_gnt = 0;
        chk("abort_wait", 64'(mem_req_o), 64'd0);
        rst_i = 1;
        #1 check_reset_vals("abort_rst");
        @(negedge clk_i);
        rst_i = 0; m_rvalid = 1; m_rdata = beat(64'h8000_0000);
        @(negedge clk_i);
        m_rvalid = 0;
        chk("late_valid", 64'(word_valid_o), 64'd0);
        chk("late_cycles1", cycles_o, 64'd1);
        repeat (3) @(negedge clk_i);
        chk("late_valid2", 64'(word_valid_o), 64'd0);
        chk("late_req", 64'(mem_req_o), 64'd0);
        chk("late_cycles4", cycles_o, 64'd4);
        chk("late_nwords", 64'(nwords), 64'd0);
        auto_mem = 1;

        run_dump("recover", 64'h8000_0000, 64'h8000_0010, 64'h1, 6, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ara_sig_dumper.md
ARA_SIG_DUMPER -- requirements
Module: ara_sig_dumper

Interface
REQ-001 Parameter DataWidth, default 128: memory read beat width in bits; multiple of 32, range 32..1024.
REQ-002 Parameter AddrWidth, default 64: byte address width.
REQ-003 Parameter CntWidth, default 64: width of the runtime cycle counter.
REQ-004 clk_i  input  1  the single clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 exit_i  input  64  tohost word; bit0 = end-of-computation, bits[63:1] = exit code.
REQ-007 sig_begin_i  input  AddrWidth  signature start byte address, 4-byte aligned, inclusive.
REQ-008 sig_end_i  input  AddrWidth  signature end byte address, 4-byte aligned, exclusive.
REQ-009 mem_req_o  output  1  memory read request valid.
REQ-010 mem_addr_o  output  AddrWidth  beat-aligned read byte address.
REQ-011 mem_gnt_i  input  1  request accepted when mem_req_o && mem_gnt_i.
REQ-012 mem_rvalid_i  input  1  read data valid.
REQ-013 mem_rdata_i  input  DataWidth  read beat.
REQ-014 word_valid_o  output  1  signature word valid.
REQ-015 word_ready_i  input  1  consumer ready; transfer on valid && ready.
REQ-016 word_o  output  32  signature word.
REQ-017 done_o  output  1  dump complete, sticky until reset.
REQ-018 fail_o  output  1  latched exit code nonzero.
REQ-019 exit_code_o  output  63  latched exit_i[63:1].
REQ-020 cycles_o  output  CntWidth  cycles from reset release to EOC detection.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, EMIT, DONE.
REQ-022 IDLE: cycle counter SHALL increment each cycle, saturating at all-ones; on exit_i[0]=1 SHALL latch exit_i[63:1], sig_begin_i, sig_end_i, freeze counter, then go REQ, or DONE if sig_begin_i >= sig_end_i.
REQ-023 Counter value presented on cycles_o SHALL be the count excluding the detection cycle itself and SHALL be held after IDLE.
REQ-024 REQ: mem_req_o=1, mem_addr_o = current word address rounded down to DataWidth/8; held stable until grant; on grant go WAIT.
REQ-025 Exactly one read outstanding; mem_rvalid_i outside WAIT SHALL be ignored.
REQ-026 WAIT: on mem_rvalid_i SHALL capture mem_rdata_i into a beat buffer and go EMIT.
REQ-027 EMIT: word_o = buffer bits [32*k+31:32*k], k = (word address / 4) mod (DataWidth/32); lowest address word first.
REQ-028 word_valid_o SHALL stay high and word_o stable until accepted; valid SHALL NOT depend on word_ready_i.
REQ-029 On each transfer word address += 4; if it equals latched end go DONE; else if k wraps to 0 go REQ; else stay EMIT.
REQ-030 Unaligned begin (mid-beat) SHALL start at the correct k; end mid-beat SHALL emit no words past end.
REQ-031 DONE: done_o=1, all request/valid outputs 0; exit_i ignored; terminal until reset.
REQ-032 fail_o = (latched exit code != 0), valid from cycle after detection; a nonzero code SHALL still perform the full dump.
REQ-033 Word address arithmetic SHALL be AddrWidth bits; sig_end_i = 0 with nonzero begin SHALL be treated as begin >= end (empty dump).
REQ-034 Throughput: at most one word per cycle; zero-latency memory yields W words per (W+2) cycles, W = DataWidth/32.

Reset
REQ-035 Reset SHALL be asynchronous active-high and SHALL abort any state mid-operation, including an ungranted request or pending read.
REQ-036 Reset values: state IDLE, counter 0, mem_req_o 0, mem_addr_o 0, word_valid_o 0, word_o 0, done_o 0, fail_o 0, exit_code_o 0, cycles_o 0.
REQ-037 A read response arriving after reset release SHALL be ignored (state IDLE).

Verification
REQ-038 DataWidth=128, begin=0x8000_0000, end=0x8000_0020, exit_i=1 at cycle 100, mem grants immediately -> 8 words in address order, cycles_o=100, done_o=1, fail_o=0.
REQ-039 begin=0x8000_0008, end=0x8000_0014 -> words from beat 0 k=2,3 then beat 1 k=0; exactly 3 words; 2 memory requests.
REQ-040 exit_i=0x7 (code 3) -> fail_o=1, exit_code_o=3, dump still completes.
REQ-041 word_ready_i toggled randomly, mem_gnt_i delayed 0..5 cycles -> word_o/mem_addr_o stable while stalled, no words lost or duplicated.
REQ-042 begin=end=0x8000_0040 -> DONE one cycle after detection, zero words, zero requests.
REQ-043 rst_i asserted in WAIT, rvalid arrives after release -> outputs at reset values, no word emitted, counter restarts from 0.
